// File: rtl/mem_arbiter.sv
// Shared-memory arbiter for the fetch and memory pipeline stages.
// Data accesses win ties; a stuck access is aborted after MAX_WAIT cycles.
module mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] if_rdata,
    output logic [31:0] dm_rdata,
    output logic        if_done,
    output logic        dm_done,
    output logic        stall,
    output logic        err
);

    localparam int CW = (MAX_WAIT > 15) ? $clog2(MAX_WAIT + 1) : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          dm_live;
    logic          if_live;
    logic          busy;
    logic          timeout;
    logic          finish;

    // A request still high during its own done cycle is stale and ignored.
    assign dm_live = dm_req & ~dm_done;
    assign if_live = if_req & ~if_done;

    assign busy    = (state == DATA) || (state == FETCH);
    assign timeout = busy & ~mem_ready & (cnt == CW'(MAX_WAIT - 1));
    assign finish  = busy & (mem_ready | timeout);

    // Freeze the pipeline while any requester is still waiting.
    assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

    // Next-state arbitration and memory-side drive.
    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        unique case (state)
            IDLE: begin
                if (dm_live) begin
                    state_n = DATA;
                end else if (if_live) begin
                    state_n = FETCH;
                end
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                if (finish) begin
                    state_n = if_live ? FETCH : IDLE;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = if_addr;
                if (finish) begin
                    state_n = dm_live ? DATA : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Wait counter: cleared on every completion (state entry), saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!busy || finish) begin
            cnt <= '0;
        end else if (cnt != CW'(MAX_WAIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Completion pulses, read-data capture and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            if_rdata <= 32'h0;
            dm_rdata <= 32'h0;
            err      <= 1'b0;
        end else begin
            if_done <= finish & (state == FETCH);
            dm_done <= finish & (state == DATA);
            if (finish && state == FETCH) begin
                if_rdata <= timeout ? 32'h0 : mem_rdata;
            end
            if (finish && state == DATA) begin
                if (timeout) begin
                    dm_rdata <= 32'h0;
                end else if (!dm_we) begin
                    dm_rdata <= mem_rdata;
                end
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule
